// File: rtl/ks_sum_32b_pipe.sv
// Kogge-Stone post-processing stage: sum, carry-out and signed overflow, with optional saturation.
// The result sits in an output register plus one skid word behind a valid/ready handshake, with a sticky overflow flag.
//
// state | meaning
// EMPTY | nothing held; o_valid=0, o_ready=1
// ONE   | OUT holds a word; o_valid=1, o_ready=1
// TWO   | OUT and SKID hold words; o_valid=1, o_ready=0
module ks_sum_32b_pipe #(
  parameter int unsigned SAT_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_c0,
  input  logic [31:0] i_pk,
  input  logic [31:0] i_gk,
  input  logic        i_sat,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_sum,
  output logic        o_cout,
  output logic        o_ovf,
  output logic        o_ovf_sticky,
  input  logic        i_ovf_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t      state_q, state_nxt;
  logic [31:0] sum_raw, sum_new;
  logic        cout_new, ovf_new, sat_hit;
  logic [33:0] word_new, out_q, skid_q;
  logic        ready_q, sticky_q;
  logic        accept, xfer;
  logic        load_out_new, load_out_skid, load_skid;

  assign sum_raw  = i_pk ^ {i_gk[30:0], i_c0};
  assign cout_new = i_gk[31];
  assign ovf_new  = i_gk[31] ^ i_gk[30];

  // Saturation direction follows the true sign of the result, which is the carry out of bit 31.
  always_comb begin
    sat_hit = (SAT_EN != 0) && i_sat && ovf_new;
    sum_new = sum_raw;
    if (sat_hit) begin
      sum_new = i_gk[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  assign word_new = {sum_new, cout_new, ovf_new};

  assign o_valid = (state_q != EMPTY);
  assign o_ready = ready_q;
  assign accept  = i_valid & ready_q;
  assign xfer    = o_valid & i_ready;

  always_comb begin
    state_nxt     = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_out_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && !xfer) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (accept && xfer) begin
          load_out_new = 1'b1;
        end else if (xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          state_nxt     = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // o_ready is registered from the next state so it never depends on i_ready combinationally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= EMPTY;
      ready_q  <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      ready_q  <= (state_nxt != TWO);
      sticky_q <= (xfer & out_q[0]) | (sticky_q & ~i_ovf_clr);
      if (load_out_new) begin
        out_q <= word_new;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= word_new;
      end
    end
  end

  assign o_sum        = out_q[33:2];
  assign o_cout       = out_q[1];
  assign o_ovf        = out_q[0];
  assign o_ovf_sticky = sticky_q;

endmodule
